// File: rtl/palindrome_gen.sv
`default_nettype none
// ============================================================================
//  Module      : palindrome_gen
//  Description : Serial palindrome transmitter. Accepts a HALF_W-bit
//                half-word over a valid/ready handshake and emits it one bit
//                per clock, MSB first, followed by its mirror image. With
//                ODD=1 the pivot bit is shared, so frames are 2*HALF_W-1 bits
//                long; with ODD=0 they are 2*HALF_W bits long.
//
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous reset, active low
//                half_i     - half-word, captured on acceptance
//                valid_i    - half_i is valid
//                ready_o    - a half-word can be accepted this cycle
//                x_o        - serial data bit (0 when x_valid_o is low)
//                x_valid_o  - x_o carries a frame bit
//                last_o     - x_o is the final bit of the frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module palindrome_gen #(
    parameter int HALF_W = 2,
    parameter int ODD    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HALF_W-1:0] half_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              x_o,
    output logic              x_valid_o,
    output logic              last_o
);

    localparam int c_cnt_w = $clog2(2 * HALF_W) + 1;

    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(HALF_W);
    localparam logic [c_cnt_w-1:0] c_half_m1  = c_cnt_w'(HALF_W - 1);
    localparam logic [c_cnt_w-1:0] c_odd      = c_cnt_w'(ODD);
    // Index of the final frame bit: L-1 = 2*HALF_W-ODD-1
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(2 * HALF_W - ODD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    state_t               r_state;
    logic [HALF_W-1:0]    r_half;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_x;
    logic                 r_x_valid;
    logic                 r_last;

    logic [c_cnt_w-1:0]   w_next_cnt;
    logic [c_cnt_w-1:0]   w_next_pos;
    logic                 w_next_bit;
    logic                 w_accept;

    // Ready depends only on registered state, never on valid_i.
    assign ready_o   = (r_state == IDLE) || r_last;
    assign w_accept  = valid_i && ready_o;

    assign x_o       = r_x;
    assign x_valid_o = r_x_valid;
    assign last_o    = r_last;

    // Select the half-word bit for the next frame position. Forward positions
    // walk down from the MSB; mirror positions walk back up starting at ODD,
    // which skips the shared pivot when the frame length is odd.
    always_comb begin
        w_next_cnt = r_count + c_one;
        if (w_next_cnt < c_half) begin
            w_next_pos = c_half_m1 - w_next_cnt;
        end else begin
            w_next_pos = w_next_cnt - c_half + c_odd;
        end
        w_next_bit = 1'b0;
        for (int i = 0; i < HALF_W; i++) begin
            if (w_next_pos == c_cnt_w'(i)) begin
                w_next_bit = r_half[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_half    <= '0;
            r_count   <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_accept) begin
            // New frame, either from IDLE or back-to-back on a last bit.
            // A one-bit frame is complete on its first (and only) bit.
            r_state   <= FWD;
            r_half    <= half_i;
            r_count   <= '0;
            r_x       <= half_i[HALF_W-1];
            r_x_valid <= 1'b1;
            r_last    <= (c_last_idx == '0);
        end else if (r_last || (r_state == IDLE)) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_count   <= w_next_cnt;
            r_x       <= w_next_bit;
            r_last    <= (w_next_cnt == c_last_idx);
            r_state   <= (w_next_cnt < c_half) ? FWD : REV;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palindrome_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palindrome_gen
//  Description : Self-checking bench for palindrome_gen. Three instances:
//                defaults (HALF_W=2, ODD=1), even/wide (HALF_W=3, ODD=0)
//                and the one-bit frame corner (HALF_W=1, ODD=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palindrome_gen;

    logic clk;
    logic reset;

    logic [1:0] half_a;  logic valid_a;
    logic ready_a, x_a, xv_a, last_a;
    logic [2:0] half_b;  logic valid_b;
    logic ready_b, x_b, xv_b, last_b;
    logic [0:0] half_c;  logic valid_c;
    logic ready_c, x_c, xv_c, last_c;

    int n_tests = 0;
    int n_fail  = 0;

    palindrome_gen #(.HALF_W(2), .ODD(1)) u_dut_a (
        .clk(clk), .reset(reset), .half_i(half_a), .valid_i(valid_a),
        .ready_o(ready_a), .x_o(x_a), .x_valid_o(xv_a), .last_o(last_a)
    );
    palindrome_gen #(.HALF_W(3), .ODD(0)) u_dut_b (
        .clk(clk), .reset(reset), .half_i(half_b), .valid_i(valid_b),
        .ready_o(ready_b), .x_o(x_b), .x_valid_o(xv_b), .last_o(last_b)
    );
    palindrome_gen #(.HALF_W(1), .ODD(1)) u_dut_c (
        .clk(clk), .reset(reset), .half_i(half_c), .valid_i(valid_c),
        .ready_o(ready_c), .x_o(x_c), .x_valid_o(xv_c), .last_o(last_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instance A) -----------------------
    typedef bit bq_t[$];

    // Frame bits straight from the rule: MSB..LSB, then bit ODD..MSB.
    function automatic bq_t make_frame(int hw, int odd, int h);
        bq_t q;
        for (int k = hw - 1; k >= 0; k--) q.push_back(bit'((h >> k) & 1));
        for (int j = odd; j < hw; j++)    q.push_back(bit'((h >> j) & 1));
        return q;
    endfunction

    bit  m_cur;       // bit currently on x_o
    bit  m_cv;        // a frame bit is currently shown
    bq_t m_rem;       // bits still to come in the current frame

    function automatic logic [3:0] exp_a();
        bit lst;
        lst = m_cv && (m_rem.size() == 0);
        return {(!m_cv || lst), m_cv, lst, (m_cv ? m_cur : 1'b0)};
    endfunction

    // Advance one clock for instance A and keep the model in step.
    task automatic tick_a(output bit acc);
        bq_t f;
        acc = valid_a && (!m_cv || (m_rem.size() == 0));
        @(posedge clk);
        if (!reset) begin
            m_cv = 0; m_rem.delete(); acc = 0;
        end else if (acc) begin
            f = make_frame(2, 1, int'(half_a));
            m_cur = f[0]; m_cv = 1; m_rem.delete();
            for (int i = 1; i < f.size(); i++) m_rem.push_back(f[i]);
        end else if (m_rem.size() > 0) begin
            m_cur = m_rem.pop_front();
        end else begin
            m_cv = 0;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        bit acc;
        valid_a = 1; half_a = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick_a(acc);
            n_tests++;
            if ({ready_a, xv_a, last_a, x_a} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: {rdy,xv,last,x} got %b want 1000", i, {ready_a, xv_a, last_a, x_a});
            end
            n_tests++;
            if ({xv_b, x_b, last_b, xv_c, x_c, last_c} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold_bc[%0d]: got %b want 000000", i, {xv_b, x_b, last_b, xv_c, x_c, last_c});
            end
        end
        reset = 1; valid_a = 0;
        tick_a(acc);
        n_tests++;
        if ({ready_a, xv_a, last_a, x_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 1000", {ready_a, xv_a, last_a, x_a});
        end
    endtask

    task automatic test_single();
        bit acc;
        logic [3:0] want [4] = '{4'b0101, 4'b0100, 4'b1111, 4'b1000};
        valid_a = 1; half_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick_a(acc);
            valid_a = 0; half_a = 2'b01;   // later changes must not matter
            n_tests++;
            if ({ready_a, xv_a, last_a, x_a} !== want[i]) begin
                n_fail++;
                $display("FAIL single[%0d]: {rdy,xv,last,x} got %b want %b", i, {ready_a, xv_a, last_a, x_a}, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [3:0] want [7] = '{4'b0100, 4'b0101, 4'b1110,
                                 4'b0101, 4'b0101, 4'b1111, 4'b1000};
        valid_a = 1; half_a = 2'b01;
        for (int i = 0; i < 7; i++) begin
            tick_a(acc);
            if (i == 0) half_a = 2'b11;
            if (i == 3) valid_a = 0;
            n_tests++;
            if ({ready_a, xv_a, last_a, x_a} !== want[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: {rdy,xv,last,x} got %b want %b", i, {ready_a, xv_a, last_a, x_a}, want[i]);
            end
        end
    endtask

    task automatic test_even_wide();
        logic [3:0] want [7] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100,
                                 4'b0101, 4'b1111, 4'b1000};
        valid_b = 1; half_b = 3'b110;
        for (int i = 0; i < 7; i++) begin
            tick();
            valid_b = 0; half_b = 3'b000;
            n_tests++;
            if ({ready_b, xv_b, last_b, x_b} !== want[i]) begin
                n_fail++;
                $display("FAIL even_wide[%0d]: {rdy,xv,last,x} got %b want %b", i, {ready_b, xv_b, last_b, x_b}, want[i]);
            end
        end
    endtask

    task automatic test_single_bit();
        logic [3:0] want;
        logic h;
        valid_c = 1; half_c = 1'b1;
        tick();
        valid_c = 0;
        n_tests++;
        if ({ready_c, xv_c, last_c, x_c} !== 4'b1111) begin
            n_fail++;
            $display("FAIL l1_single: {rdy,xv,last,x} got %b want 1111", {ready_c, xv_c, last_c, x_c});
        end
        tick();
        n_tests++;
        if ({ready_c, xv_c, last_c, x_c} !== 4'b1000) begin
            n_fail++;
            $display("FAIL l1_idle: got %b want 1000", {ready_c, xv_c, last_c, x_c});
        end
        // Continuous one-bit frames with valid held high.
        valid_c = 1;
        for (int i = 0; i < 8; i++) begin
            h = 1'($urandom_range(0, 1));
            half_c = h;
            tick();
            want = {3'b111, h};
            n_tests++;
            if ({ready_c, xv_c, last_c, x_c} !== want) begin
                n_fail++;
                $display("FAIL l1_stream[%0d]: got %b want %b", i, {ready_c, xv_c, last_c, x_c}, want);
            end
        end
        valid_c = 0;
        tick();
    endtask

    task automatic test_mid_reset();
        bit acc;
        logic [3:0] want [4] = '{4'b0100, 4'b0100, 4'b1110, 4'b1000};
        valid_a = 1; half_a = 2'b10;
        tick_a(acc);
        valid_a = 0;
        tick_a(acc);
        n_tests++;
        if ({xv_a, x_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_2nd_bit: {xv,x} got %b want 10", {xv_a, x_a});
        end
        #1 reset = 0;
        m_cv = 0; m_rem.delete();
        #1;
        n_tests++;
        if ({ready_a, xv_a, last_a, x_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want 1000", {ready_a, xv_a, last_a, x_a});
        end
        tick_a(acc);
        n_tests++;
        if ({ready_a, xv_a, last_a, x_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_held: got %b want 1000", {ready_a, xv_a, last_a, x_a});
        end
        reset = 1; valid_a = 1; half_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick_a(acc);
            valid_a = 0;
            n_tests++;
            if ({ready_a, xv_a, last_a, x_a} !== want[i]) begin
                n_fail++;
                $display("FAIL midrst_after[%0d]: got %b want %b", i, {ready_a, xv_a, last_a, x_a}, want[i]);
            end
        end
    endtask

    task automatic test_loopback();
        bit   acc;
        int   frames = 0;
        int   cycles = 0;
        int   sent[$];
        bq_t  obs;
        bq_t  ref_f;
        bit   pal;
        while (frames < 400 && cycles < 5000) begin
            valid_a = ($urandom_range(0, 3) != 0);
            half_a  = 2'($urandom_range(0, 3));
            tick_a(acc);
            if (acc) sent.push_back(int'(half_a));
            cycles++;
            n_tests++;
            if ({ready_a, xv_a, last_a, x_a} !== exp_a()) begin
                n_fail++;
                $display("FAIL loop_cycle[%0d]: {rdy,xv,last,x} got %b want %b", cycles, {ready_a, xv_a, last_a, x_a}, exp_a());
            end
            if (xv_a === 1'b1) obs.push_back(x_a);
            if (last_a === 1'b1) begin
                pal = 1;
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i] != obs[obs.size() - 1 - i]) pal = 0;
                n_tests++;
                if (pal !== 1'b1 || obs.size() != 3) begin
                    n_fail++;
                    $display("FAIL loop_palindrome[%0d]: len %0d pal %0d want len 3 pal 1", frames, obs.size(), pal);
                end
                if (sent.size() > 0) begin
                    ref_f = make_frame(2, 1, sent.pop_front());
                    n_tests++;
                    if (obs != ref_f) begin
                        n_fail++;
                        $display("FAIL loop_frame[%0d]: bits %p want %p", frames, obs, ref_f);
                    end
                end else begin
                    n_tests++; n_fail++;
                    $display("FAIL loop_frame[%0d]: frame with no accepted half-word", frames);
                end
                obs.delete();
                frames++;
            end
        end
        valid_a = 0;
        n_tests++;
        if (frames < 400) begin
            n_fail++;
            $display("FAIL loop_budget: %0d frames in %0d cycles, want 400", frames, cycles);
        end
    endtask

    initial begin
        reset = 0;
        valid_a = 0; half_a = '0;
        valid_b = 0; half_b = '0;
        valid_c = 0; half_c = '0;
        m_cv = 0; m_cur = 0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_even_wide();
        test_single_bit();
        test_mid_reset();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palindrome_gen.md
# palindrome_gen

Serial palindrome transmitter: accepts a HALF_W-bit half-word over a valid/ready handshake and emits a full palindrome one bit per clock, MSB first, followed by its mirror. This is the stimulus source for the serial palindrome detector: it drives that block's single-bit input so that every transmitted frame is a palindrome by construction. With defaults it emits back-to-back 3-bit palindromes.

## Interface
- HALF_W, 2: width of the half-word; legal range 1..16.
- ODD, 1: 1 means the pivot bit is shared and the frame length is 2*HALF_W-1; 0 means the frame length is 2*HALF_W.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0); released synchronously by the bench.
- half_i  in  HALF_W  half-word to transmit; sampled on acceptance.
- valid_i  in  1  half_i is valid.
- ready_o  out  1  the block can accept a half-word this cycle.
- x_o  out  1  serial data bit.
- x_valid_o  out  1  x_o carries a frame bit this cycle.
- last_o  out  1  x_o is the final bit of the current frame.

## Operation
- Frame length L = 2*HALF_W-ODD. Frame order: half[HALF_W-1], …, half[0], then half[ODD], half[ODD+1], …, half[HALF_W-1].
- Example, HALF_W=2, ODD=1, half=2'b10: bits 1,0,1. With ODD=0 the same half gives 1,0,0,1.
- Acceptance happens when valid_i && ready_o at a rising edge. half_i is copied into an internal shift register and the bit counter is loaded.
- States:
  - IDLE: x_valid_o=0, ready_o=1. Acceptance moves to FWD.
  - FWD: emits the HALF_W forward bits. After the last forward bit it moves to REV. When HALF_W=1 and ODD=1 (L=1), REV is skipped.
  - REV: emits the HALF_W-ODD mirror bits.
  - On the last bit (last_o=1):
    - if a new half-word is accepted in the same cycle, go to FWD (back-to-back, no gap);
    - otherwise go to IDLE.
- ready_o = (state==IDLE) || last_o. The output is combinational from registered state only, never from valid_i.
- Bit counter width is $clog2(2*HALF_W)+1. It counts 0..L-1, and last_o = (count==L-1) while x_valid_o is high.
- half_i and valid_i changes after acceptance have no effect on the frame in flight.
- x_o is held at 0 whenever x_valid_o=0.

## Timing
- Reset values, applied asynchronously while reset is low:
  - state = IDLE;
  - x_o = 0, x_valid_o = 0, last_o = 0;
  - ready_o = 1 (IDLE), but no acceptance occurs while reset is low.
- Latency: the first frame bit appears on x_o/x_valid_o in the cycle after the accepting edge, i.e. registered output with 1-cycle latency.
- Throughput: with valid_i held high, x_valid_o stays high continuously, one frame every L cycles.
- x_o, x_valid_o and last_o are registered; they change only on rising clk edges or asynchronously on reset assertion.
- Reset asserted mid-frame aborts the frame immediately: outputs go to their reset values and there is no partial continuation after release.
- The first acceptance is possible at the first rising edge with reset=1.

## Test plan
- Reset: hold reset=0 for 2 cycles with valid_i=1 and half_i=2'b11 -> x_valid_o=0, x_o=0, last_o=0 throughout; no frame starts until after release.
- Single frame, defaults: after reset, one valid pulse with half_i=2'b10 -> x_o=1,0,1 on the 3 following cycles; x_valid_o=1,1,1; last_o=0,0,1; ready_o=0,0,1; then IDLE.
- Back-to-back: valid_i held high, half_i=2'b01 then 2'b11 -> x_o=0,1,0,1,1,1 with no gap in x_valid_o; ready_o high only in IDLE and on each last bit.
- Even/wide: HALF_W=3, ODD=0, half_i=3'b110 -> x_o=1,1,0,0,1,1; last_o on the 6th bit. Edge case HALF_W=1, ODD=1, half_i=1 -> single bit 1 with last_o=1.
- Mid-frame reset: assert reset during the 2nd bit of 2'b10 -> outputs 0 immediately; after release plus a new acceptance of 2'b00 -> 0,0,0 cleanly.
- Loopback: drive the detector's x_i from x_o for 400 random frames (defaults) -> the detector flags a palindrome on every last_o cycle; the bench also checks every frame against a reference model of the bit order.
